// File: rtl/prog_sequencer.sv
// Instruction feeder: fetches program words from synchronous memory, issues each
// to the core with a one-cycle run pulse, and waits for done (halt/stop/timeout aware).
module prog_sequencer #(
   parameter int         AW       = 8,
   parameter logic [2:0] IMM_OPC  = 3'b001,
   parameter logic [2:0] HALT_OPC = 3'b111,
   parameter int         TIMEOUT  = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic          stop,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [15:0]   mem_rdata,
   output logic [15:0]   proc_din,
   output logic          proc_run,
   input  logic          proc_done,
   output logic          busy,
   output logic          halted,
   output logic          error,
   output logic [AW-1:0] pc,
   output logic [15:0]   instr_count
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_WAIT_MEM, S_FETCH_IMM, S_WAIT_IMM,
      S_ISSUE, S_WAIT_DONE, S_HALTED, S_ERROR
   } state_t;

   state_t        state, state_next;
   logic [15:0]   instr;
   logic [15:0]   imm;
   logic          stop_latch;
   logic [CW-1:0] tcount;
   logic          is_imm;

   assign is_imm = (instr[15:13] == IMM_OPC);
   assign halted = (state == S_HALTED);
   assign error  = (state == S_ERROR);
   assign busy   = (state != S_IDLE) && (state != S_HALTED) && (state != S_ERROR);

   always_comb begin
      state_next = state;
      mem_rd     = 1'b0;
      mem_addr   = pc;
      proc_run   = 1'b0;
      case (state)
         S_IDLE, S_HALTED, S_ERROR: begin
            if (start) state_next = S_FETCH;
         end
         S_FETCH: begin
            mem_rd     = 1'b1;
            state_next = S_WAIT_MEM;
         end
         S_WAIT_MEM: begin
            if (mem_rdata[15:13] == HALT_OPC)     state_next = S_HALTED;
            else if (mem_rdata[15:13] == IMM_OPC) state_next = S_FETCH_IMM;
            else                                  state_next = S_ISSUE;
         end
         S_FETCH_IMM: begin
            mem_rd     = 1'b1;
            mem_addr   = pc + AW'(1);
            state_next = S_WAIT_IMM;
         end
         S_WAIT_IMM: state_next = S_ISSUE;
         S_ISSUE: begin
            proc_run   = 1'b1;
            state_next = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // A stop arriving in the completion cycle itself is honoured too.
            if (proc_done)                          state_next = (stop_latch || stop) ? S_HALTED : S_FETCH;
            else if (tcount == CW'(TIMEOUT - 1))    state_next = S_ERROR;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         pc          <= '0;
         instr       <= '0;
         imm         <= '0;
         proc_din    <= '0;
         instr_count <= '0;
         stop_latch  <= 1'b0;
         tcount      <= '0;
      end else begin
         state <= state_next;
         if (busy && stop) stop_latch <= 1'b1;
         case (state)
            S_IDLE, S_HALTED, S_ERROR: begin
               if (start) begin
                  pc          <= start_addr;
                  instr_count <= '0;
                  stop_latch  <= 1'b0;
               end
            end
            S_WAIT_MEM: begin
               instr <= mem_rdata;
               if (mem_rdata[15:13] != HALT_OPC && mem_rdata[15:13] != IMM_OPC)
                  proc_din <= mem_rdata;
            end
            S_WAIT_IMM: begin
               imm      <= mem_rdata;
               proc_din <= instr;
            end
            // din switches to the immediate from the first cycle after run.
            S_ISSUE: begin
               tcount <= '0;
               if (is_imm) proc_din <= imm;
            end
            S_WAIT_DONE: begin
               if (proc_done) begin
                  pc          <= pc + (is_imm ? AW'(2) : AW'(1));
                  instr_count <= instr_count + 16'd1;
               end else begin
                  tcount <= tcount + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: memory and core models, run-pulse scoreboard,
// immediate-assertion checks on program flow, wrap, timeout, stop and reset.
module tb_prog_sequencer;

   localparam int TIMEOUT = 16;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  start_addr;
   logic        stop;
   logic        mem_rd;
   logic [7:0]  mem_addr;
   logic [15:0] mem_rdata;
   logic [15:0] proc_din;
   logic        proc_run;
   logic        proc_done;
   logic        busy;
   logic        halted;
   logic        error;
   logic [7:0]  pc;
   logic [15:0] instr_count;

   prog_sequencer #(.AW(8), .IMM_OPC(3'b001), .HALT_OPC(3'b111), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stop(stop),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .proc_din(proc_din), .proc_run(proc_run), .proc_done(proc_done),
      .busy(busy), .halted(halted), .error(error), .pc(pc), .instr_count(instr_count)
   );

   typedef struct {
      logic [15:0] run_din;
      logic [15:0] hold_din;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] mem [256];
   int          dly;
   int          remain;
   int          vectors;
   int          miscompares;
   int          run_count;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   // Core model: done pulses dly cycles after run; dly==0 never answers.
   always @(posedge clk) begin
      if (!reset) begin
         remain    <= 0;
         proc_done <= 1'b0;
      end else if (proc_run) begin
         remain    <= (dly > 0) ? dly - 1 : 0;
         proc_done <= (dly == 1);
      end else if (remain > 0) begin
         remain    <= remain - 1;
         proc_done <= (remain == 1);
      end else begin
         proc_done <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: each run pulse pops one expected issue and checks din on the run
   // cycle and on the following cycle.
   initial begin
      exp_t e;
      logic        hold_chk;
      logic [15:0] hold_exp;
      hold_chk = 1'b0;
      hold_exp = '0;
      forever begin
         @(negedge clk);
         if (hold_chk) begin
            check("din_after_run", proc_din, hold_exp);
            hold_chk = 1'b0;
         end
         if (proc_run === 1'b1) begin
            run_count++;
            check("run_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("din_on_run", proc_din, e.run_din);
               hold_exp = e.hold_din;
               hold_chk = 1'b1;
            end
         end
      end
   end

   task automatic start_at(input logic [7:0] a);
      @(negedge clk);
      start      = 1'b1;
      start_addr = a;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic wait_run(input string tag, output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (proc_run !== 1'b1 && k < 40);
      check(tag, proc_run, 1'b1);
   endtask

   task automatic wait_halt(input string tag);
      int n;
      n = 0;
      while (halted !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(tag, halted, 1'b1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_halted"}, halted, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_pc"}, pc, 0);
      check({tag, "_count"}, instr_count, 0);
      check({tag, "_din"}, proc_din, 0);
      check({tag, "_mem_rd"}, mem_rd, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_run"}, proc_run, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int rc0;
      int rd_seen;
      vectors     = 0;
      miscompares = 0;
      run_count   = 0;
      reset       = 1'b0;
      start       = 1'b0;
      stop        = 1'b0;
      start_addr  = '0;
      dly         = 1;
      for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
      mem[0] = 16'h0040; mem[1] = 16'h4040; mem[2] = 16'hE000;
      mem[5] = 16'h2000; mem[6] = 16'h1234;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b1;

      // Plain program with done after 1 then 3 cycles.
      exp_q.push_back('{16'h0040, 16'h0040});
      exp_q.push_back('{16'h4040, 16'h4040});
      rc0 = run_count;
      start_at(8'h00);
      check("t1_fetch_rd", mem_rd, 1);
      check("t1_fetch_addr", mem_addr, 8'h00);
      wait_run("t1_run", k);
      check("t1_latency", k, 2);
      @(negedge clk);
      dly = 3;
      wait_halt("t1_halted");
      check("t1_pc", pc, 8'h02);
      check("t1_count", instr_count, 2);
      check("t1_busy", busy, 0);
      check("t1_runs", run_count - rc0, 2);
      check("t1_din_held", proc_din, 16'h4040);

      // Immediate instruction at 5.
      dly = 2;
      exp_q.push_back('{16'h2000, 16'h1234});
      start_at(8'h05);
      check("t2_fetch_addr", mem_addr, 8'h05);
      @(negedge clk);
      @(negedge clk);
      check("t2_imm_rd", mem_rd, 1);
      check("t2_imm_addr", mem_addr, 8'h06);
      wait_run("t2_run", k);
      check("t2_latency", k, 2);
      wait_halt("t2_halted");
      check("t2_pc", pc, 8'h07);
      check("t2_count", instr_count, 1);

      // Immediate at the top of memory wraps to address 0.
      mem[8'hFF] = 16'h3005; mem[0] = 16'hBEEF; mem[1] = 16'hE000;
      exp_q.push_back('{16'h3005, 16'hBEEF});
      start_at(8'hFF);
      check("t3_fetch_addr", mem_addr, 8'hFF);
      @(negedge clk);
      @(negedge clk);
      check("t3_imm_addr", mem_addr, 8'h00);
      wait_run("t3_run", k);
      wait_halt("t3_halted");
      check("t3_pc", pc, 8'h01);

      // Core never answers: done timeout.
      dly = 0;
      mem[8'h10] = 16'h4040;
      exp_q.push_back('{16'h4040, 16'h4040});
      start_at(8'h10);
      wait_run("t4_run", k);
      repeat (TIMEOUT - 1) @(negedge clk);
      check("t4_no_error_yet", error, 0);
      check("t4_still_busy", busy, 1);
      repeat (2) @(negedge clk);
      check("t4_error", error, 1);
      check("t4_busy", busy, 0);
      check("t4_pc", pc, 8'h10);
      check("t4_count", instr_count, 0);
      start_at(8'h20);
      check("t4_error_cleared", error, 0);
      check("t4_restart_busy", busy, 1);
      wait_halt("t4_restart_halted");
      check("t4_restart_pc", pc, 8'h20);

      // Stop one cycle after run of the instruction at 3.
      dly = 3;
      mem[3] = 16'h5123; mem[4] = 16'h0040;
      exp_q.push_back('{16'h5123, 16'h5123});
      start_at(8'h03);
      wait_run("t5_run", k);
      rd_seen = 0;
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      for (int i = 0; i < 20 && halted !== 1'b1; i++) begin
         if (mem_rd === 1'b1) rd_seen++;
         @(negedge clk);
      end
      check("t5_halted", halted, 1);
      check("t5_pc", pc, 8'h04);
      check("t5_count", instr_count, 1);
      repeat (3) begin
         if (mem_rd === 1'b1) rd_seen++;
         @(negedge clk);
      end
      check("t5_no_fetch", rd_seen, 0);
      check("t5_still_halted", halted, 1);

      // Reset in WAIT_DONE, with an ignored start while busy.
      dly = 0;
      mem[8'h30] = 16'h4040;
      exp_q.push_back('{16'h4040, 16'h4040});
      start_at(8'h30);
      wait_run("t6_run", k);
      @(negedge clk);
      start      = 1'b1;
      start_addr = 8'h55;
      @(negedge clk);
      start      = 1'b0;
      check("t6_busy_start_pc", pc, 8'h30);
      check("t6_busy", busy, 1);
      reset = 1'b0;
      @(negedge clk);
      check_zero("t6_reset_done");
      reset = 1'b1;

      // Reset in WAIT_IMM.
      mem[8'h40] = 16'h2222; mem[8'h41] = 16'h7777;
      rc0 = run_count;
      start_at(8'h40);
      @(negedge clk);
      @(negedge clk);
      check("t7_imm_addr", mem_addr, 8'h41);
      @(negedge clk);
      check("t7_wait_imm_rd", mem_rd, 0);
      reset = 1'b0;
      @(negedge clk);
      check_zero("t7_reset_imm");
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("t7_no_run", run_count - rc0, 0);
      check("t7_idle", busy, 0);
      check("sb_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
